// File: rtl/int_to_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp_pkg
// Description : Shared floating-point definitions for the FP ALU units:
//               IEEE 754 single-precision constants, the common 2-bit
//               handshake state encoding and a field-packing helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package int_to_fp_pkg;

  localparam int unsigned FP_BIAS = 127;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // State encoding shared by every FP unit driven by the ALU sequencer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_t;

  // Assemble a single-precision word from its sign/exponent/mantissa fields.
  function automatic logic [31:0] fp_pack(input logic       sign,
                                          input logic [7:0]  exp,
                                          input logic [22:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_to_fp_if.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp_if
// Description : start/done handshake bundle between the ALU sequencer and
//               the integer-to-float converter.
// Signals     : a, is_signed, start      - sequencer -> converter
//               result, done, inexact,
//               busy                     - converter -> sequencer
// Modports    : master (sequencer), slave (converter)
// Revision    : 1.0 - initial release
// ============================================================================
interface int_to_fp_if;
  logic [31:0] a;
  logic        is_signed;
  logic        start;
  logic [31:0] result;
  logic        done;
  logic        inexact;
  logic        busy;

  modport master (
    output a, is_signed, start,
    input  result, done, inexact, busy
  );

  modport slave (
    input  a, is_signed, start,
    output result, done, inexact, busy
  );
endinterface
`default_nettype wire

// File: rtl/int_to_fp.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp
// Description : Iterative 32-bit integer (signed/unsigned) to IEEE 754
//               single-precision converter, round-to-nearest-even.
//               Normalisation shifts one bit per cycle.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - int_to_fp_if.slave (a, is_signed, start in;
//                        result, done, inexact, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_fp
  import int_to_fp_pkg::*;
#(
  parameter int unsigned EXP_INIT = FP_BIAS + 31
) (
  input  wire logic     clk,
  input  wire logic     reset,
  int_to_fp_if.slave    bus
);

  fp_state_t   state_q,   state_d;
  logic        sign_q,    sign_d;
  logic [31:0] mag_q,     mag_d;
  logic [7:0]  exp_q,     exp_d;
  logic [31:0] result_q,  result_d;
  logic        done_q,    done_d;
  logic        inexact_q, inexact_d;

  // Rounding datapath, only consumed in ROUND (mag_q[31] is the hidden bit).
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_mant_sum;
  logic [7:0]  w_exp_rnd;

  assign w_mant     = mag_q[30:8];
  assign w_guard    = mag_q[7];
  assign w_sticky   = |mag_q[6:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_round_up};
  // A mantissa carry leaves the low 23 bits at zero; only the exponent moves.
  assign w_exp_rnd  = exp_q + {7'd0, w_mant_sum[23]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      result_q  <= FP_ZERO;
      done_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      done_q    <= done_d;
      inexact_q <= inexact_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    result_d  = result_q;
    done_d    = done_q;
    inexact_d = inexact_q;

    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          sign_d    = bus.is_signed & bus.a[31];
          // -2^31 negates to itself, which is exactly the wanted magnitude.
          mag_d     = (bus.is_signed & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
          exp_d     = 8'(EXP_INIT);
          inexact_d = 1'b0;
          state_d   = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mag_q == 32'd0) begin
          // Zero bypasses rounding; sign is dropped so -0 never appears.
          result_d = FP_ZERO;
          state_d  = ST_DONE;
        end else if (mag_q[31]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end

      ST_ROUND: begin
        result_d  = fp_pack(sign_q, w_exp_rnd, w_mant_sum[22:0]);
        inexact_d = w_guard | w_sticky;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        // Level-held start must not retrigger; wait for it to drop.
        done_d = 1'b1;
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.result  = result_q;
  assign bus.done    = done_q;
  assign bus.inexact = inexact_q;
  assign bus.busy    = (state_q == ST_NORM) || (state_q == ST_ROUND);

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_fp
// Description : Directed self-checking bench for int_to_fp: conversions with
//               hand-computed IEEE 754 results, latency/busy counts,
//               held-start behaviour and asynchronous reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_to_fp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_to_fp_if bus ();

  int_to_fp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one conversion with start level-held from edge 0.
  // exp_lat  : edges after edge 0 until done is seen high (n+3, or 2 for zero)
  // exp_busy : busy samples before done (NORM cycles + ROUND cycle)
  // hold     : keep start high 10 more cycles after done before dropping it
  task automatic convert(input string tag, input logic [31:0] a, input logic sgn,
                         input logic [31:0] exp_res, input logic exp_inx,
                         input int exp_lat, input int exp_busy, input bit hold);
    int lat      = 0;
    int busy_cnt = 0;
    bit got      = 1'b0;
    @(negedge clk);
    bus.a         = a;
    bus.is_signed = sgn;
    bus.start     = 1'b1;
    @(posedge clk);                    // edge 0: operand captured
    @(negedge clk);
    busy_cnt += int'(bus.busy);
    bus.a         = ~a;                // later operand changes must be ignored
    bus.is_signed = ~sgn;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      busy_cnt += int'(bus.busy);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"},   32'(lat), 32'(exp_lat));
    check({tag, "_busy_cyc"},  32'(busy_cnt), 32'(exp_busy));
    check({tag, "_result"},    bus.result, exp_res);
    check({tag, "_inexact"},   32'(bus.inexact), 32'(exp_inx));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.a = 32'h1234_5678 + 32'(i);
      end
      check({tag, "_hold_done"},   32'(bus.done), 32'd1);
      check({tag, "_hold_busy"},   32'(bus.busy), 32'd0);
      check({tag, "_hold_result"}, bus.result, exp_res);
    end
    bus.start = 1'b0;
    @(negedge clk);                    // DONE sees start low -> IDLE
    @(negedge clk);                    // IDLE clears done
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_res_keep"}, bus.result, exp_res);
  endtask

  initial begin
    reset         = 1'b1;
    bus.a         = 32'd0;
    bus.is_signed = 1'b0;
    bus.start     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result",  bus.result, 32'h0000_0000);
    check("rst_done",    32'(bus.done), 32'd0);
    check("rst_inexact", 32'(bus.inexact), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert("one_s",   32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 34, 33, 1'b0);
    convert("m5_s",    32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 32, 31, 1'b1);
    convert("m5_u",    32'hFFFF_FFFB, 1'b0, 32'h4F80_0000, 1'b1,  3,  2, 1'b0);
    convert("zero",    32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0,  2,  1, 1'b0);
    convert("tie_even",32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10,  9, 1'b0);
    convert("tie_odd", 32'h0100_0003, 1'b1, 32'h4B80_0002, 1'b1, 10,  9, 1'b0);
    convert("max_pos", 32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1,  4,  3, 1'b0);
    convert("min_neg", 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0,  3,  2, 1'b0);

    // Reset pulse mid-normalisation aborts and clears outputs immediately.
    @(negedge clk);
    bus.a         = 32'h0000_0001;
    bus.is_signed = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);                    // edge 0
    repeat (5) @(posedge clk);         // edge 5
    #1 reset = 1'b1;
    #1;
    check("abort_result",  bus.result, 32'h0000_0000);
    check("abort_done",    32'(bus.done), 32'd0);
    check("abort_busy",    32'(bus.busy), 32'd0);
    check("abort_inexact", 32'(bus.inexact), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    check("abort_idle_done", 32'(bus.done), 32'd0);

    convert("recover", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
